// File: rtl/multicycle_addsub.sv
// Sequential add/subtract/compare unit.
// Operands are accepted through a valid/ready handshake. One SLICE_WIDTH
// slice is summed per cycle with a registered carry. The result is held
// until the downstream side takes it.
//
// state | meaning
// IDLE  | ready for a new operation; i_ready=1
// BUSY  | summing one slice per cycle, LSB slice first
// DONE  | result valid; held until o_ready
module multicycle_addsub #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic                  o_cout,
  output logic                  o_lt
);

  localparam int NSLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;     // B for add, ~B for every other op
  logic [1:0]              op_q;
  logic                    carry_q;
  logic [IDXW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   y_q;
  logic                    cout_q;
  logic                    lt_q;
  logic                    valid_q;

  logic [SLICE_WIDTH:0]    slice_sum_d;
  logic                    lt_d;
  int                      slice_base;

  // Sum of the current slice (carry in from the register) and the A<B flag
  // that applies if this slice is the last one.
  always_comb begin
    slice_base  = int'(idx_q) * SLICE_WIDTH;
    slice_sum_d = {1'b0, a_q[slice_base +: SLICE_WIDTH]}
                + {1'b0, b_q[slice_base +: SLICE_WIDTH]}
                + {{SLICE_WIDTH{1'b0}}, carry_q};
    // The signed case uses ~B's MSB, which is what b_q already holds.
    // Its value is bit DATA_WIDTH of the sign-extended difference.
    case (op_q)
      2'b00:   lt_d = 1'b0;
      2'b11:   lt_d = a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1] ^ slice_sum_d[SLICE_WIDTH];
      default: lt_d = ~slice_sum_d[SLICE_WIDTH];
    endcase
  end

  // Control FSM, operand latch, slice-by-slice result and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      carry_q <= 1'b0;
      idx_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      lt_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= (i_op == 2'b00) ? i_b : ~i_b;
            op_q    <= i_op;
            carry_q <= (i_op != 2'b00);
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          y_q[slice_base +: SLICE_WIDTH] <= slice_sum_d[SLICE_WIDTH-1:0];
          carry_q <= slice_sum_d[SLICE_WIDTH];
          if (idx_q == LAST_IDX) begin
            cout_q  <= slice_sum_d[SLICE_WIDTH];
            lt_q    <= lt_d;
            valid_q <= 1'b1;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (o_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = valid_q;
  assign o_y     = y_q;
  assign o_cout  = cout_q;
  assign o_lt    = lt_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub with the default 32/8 configuration.
// A cycle-level reference computes each result from plain arithmetic.
// Directed operations also pin the expected results as literal values.
module tb_multicycle_addsub;

  localparam int DW      = 32;
  localparam int NSLICES = 4;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          i_ready;
  logic [1:0]    i_op;
  logic [DW-1:0] i_a;
  logic [DW-1:0] i_b;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_y;
  logic          o_cout;
  logic          o_lt;

  int n_vec = 0;
  int n_err = 0;

  multicycle_addsub #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_y     (o_y),
    .o_cout  (o_cout),
    .o_lt    (o_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference result: {lt, cout, y} from plain integer arithmetic.
  function automatic logic [33:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    logic        cout;
    logic        lt;
    if (op == 2'b00) begin
      s    = {1'b0, a} + {1'b0, b};
      cout = s[32];
      lt   = 1'b0;
    end else begin
      s    = {1'b0, a - b};
      cout = (a >= b);
      lt   = (op == 2'b11) ? ($signed(a) < $signed(b)) : (a < b);
    end
    return {lt, cout, s[31:0]};
  endfunction

  // Cycle-level reference: idle -> NSLICES busy cycles -> held result.
  logic        m_idle;
  logic        m_valid;
  int          m_rem;
  logic [33:0] m_pend;
  logic [33:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_rem   <= 0;
      m_pend  <= '0;
      m_res   <= '0;
    end else if (m_idle) begin
      if (i_valid) begin
        m_idle <= 1'b0;
        m_rem  <= NSLICES;
        m_pend <= ref_calc(i_op, i_a, i_b);
      end
    end else if (!m_valid) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_pend;
      end
    end else if (o_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  // Compare process: handshake flags every cycle, result fields while valid.
  always @(negedge clk) begin
    chk("i_ready", 32'(i_ready), 32'(m_idle));
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    if (m_valid) begin
      chk("model_y",    o_y,           m_res[31:0]);
      chk("model_cout", 32'(o_cout),   32'(m_res[32]));
      chk("model_lt",   32'(o_lt),     32'(m_res[33]));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!i_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!i_ready) chk("i_ready_timeout", 32'(i_ready), 32'd1);
  endtask

  // Issue one operation, check latency and literal results.
  // With consume=1, o_ready is held high and the handshake is checked too.
  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ey, input logic ec,
                       input logic el, input bit consume);
    int n = 0;
    wait_ready();
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_a     = ~a;
    i_b     = ~b;
    i_op    = ~op;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(NSLICES));
    chk({nm, "_y"},       o_y, ey);
    chk({nm, "_cout"},    32'(o_cout), 32'(ec));
    chk({nm, "_lt"},      32'(o_lt), 32'(el));
    if (consume) begin
      @(posedge clk); #1;
      chk({nm, "_taken_valid"}, 32'(o_valid), 32'd0);
      chk({nm, "_taken_ready"}, 32'(i_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    o_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(i_ready), 32'd1);
    chk("rst_y",     o_y, 32'd0);
    chk("rst_cout",  32'(o_cout), 32'd0);
    chk("rst_lt",    32'(o_lt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_ff_1",   2'b00, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    do_op("add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op("sub_5_7",    2'b01, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
    do_op("sub_7_5",    2'b01, 32'd7,         32'd5,         32'h0000_0002, 1'b1, 1'b0, 1'b1);
    do_op("cmps_m1_1",  2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
    do_op("cmpu_m1_1",  2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
    do_op("cmps_min",   2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    do_op("cmpu_min",   2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    do_op("cmps_eq",    2'b11, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result must hold while inputs churn.
    o_ready = 1'b0;
    do_op("bp", 2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      i_valid = i[0];
      i_a     = $urandom;
      i_b     = $urandom;
      i_op    = 2'(i);
      @(posedge clk); #1;
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(i_ready), 32'd0);
      chk("bp_y",     o_y, 32'h2345_6789);
      chk("bp_lt",    32'(o_lt), 32'd0);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(o_valid), 32'd0);
    chk("bp_release_ready", 32'(i_ready), 32'd1);

    // Reset mid-BUSY discards the operation at once.
    wait_ready();
    i_valid = 1'b1;
    i_op    = 2'b00;
    i_a     = 32'h1234_5678;
    i_b     = 32'h0000_0001;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_y",     o_y, 32'd0);
    chk("mid_rst_ready", 32'(i_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_no_result", 32'(o_valid), 32'd0);
    do_op("add_3_4", 2'b00, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
